// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed scan driver for a common-anode multi-digit 7-segment display
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   value_i      value to display, digit 0 = value_i[3:0]
//   load_i       1-cycle strobe capturing value_i (shown from the next frame)
//   nibble_o     nibble of the digit currently presented, for the hex decoder
//   an_o         active-low anode enables, at most one low
//   digit_idx_o  digit currently presented
//   frame_done_o 1-cycle pulse after the digit index wraps to 0
module seg7_scan_mux #(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter int BLANK_CYC     = 64,
    parameter int BLANK_LEADING = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [4*NUM_DIGITS-1:0]       value_i,
    input  logic                          load_i,
    output logic [3:0]                    nibble_o,
    output logic [NUM_DIGITS-1:0]         an_o,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx_o,
    output logic                          frame_done_o
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           r_cnt;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [4*NUM_DIGITS-1:0] r_pending;
    logic                    r_pend_v;
    logic [NUM_DIGITS-1:0]   w_nz;
    logic                    w_slot_end;
    logic                    w_wrap;
    logic                    w_supp;
    logic                    w_acc;

    assign w_slot_end = r_cnt == CNT_LAST;
    assign w_wrap     = w_slot_end && r_idx == IDX_LAST;

    // w_nz[k]: some shadow nibble at position k or above is non-zero
    always_comb begin
        w_nz  = '0;
        w_acc = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_acc   = w_acc | (|r_shadow[4*k +: 4]);
            w_nz[k] = w_acc;
        end
    end

    assign w_supp = (BLANK_LEADING != 0) && r_idx != '0 && !w_nz[r_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shadow     <= '0;
            r_pending    <= '0;
            r_pend_v     <= 1'b0;
            nibble_o     <= '0;
            an_o         <= '1;
            digit_idx_o  <= '0;
            frame_done_o <= 1'b0;
        end else begin
            r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;
            if (w_slot_end)
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            // a load landing on the wrap cycle bypasses the pending buffer
            if (w_wrap) begin
                r_shadow <= load_i ? value_i : (r_pend_v ? r_pending : r_shadow);
                r_pend_v <= 1'b0;
            end else if (load_i) begin
                r_pending <= value_i;
                r_pend_v  <= 1'b1;
            end
            nibble_o     <= r_shadow[4*r_idx +: 4];
            digit_idx_o  <= r_idx;
            an_o         <= (r_cnt < BLANK_END || w_supp) ? '1 : ~(NUM_DIGITS'(1) << r_idx);
            frame_done_o <= w_wrap;
        end
    end
endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: scoreboard bench for seg7_scan_mux with and without leading-zero blanking
module tb_seg7_scan_mux;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load_i = 1'b0;
    logic [15:0] value_i = '0;
    logic [3:0]  nib1, an1, nib2, an2;
    logic [1:0]  idx1, idx2;
    logic        fd1, fd2;

    always #5 clk = ~clk;

    seg7_scan_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYC(1), .BLANK_LEADING(0)) dut (
        .clk(clk), .rst_n(rst_n), .value_i(value_i), .load_i(load_i),
        .nibble_o(nib1), .an_o(an1), .digit_idx_o(idx1), .frame_done_o(fd1)
    );

    seg7_scan_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYC(1), .BLANK_LEADING(1)) dut_lz (
        .clk(clk), .rst_n(rst_n), .value_i(value_i), .load_i(load_i),
        .nibble_o(nib2), .an_o(an2), .digit_idx_o(idx2), .frame_done_o(fd2)
    );

    typedef struct {
        logic [3:0] nib;
        logic [3:0] an;
        logic [3:0] an2;
        logic [1:0] idx;
        logic       fd;
        int         st;
    } exp_t;

    typedef struct {
        logic [15:0] v1;
        int          a1;
        logic [15:0] v2;
        int          a2;
        logic [15:0] expv;
    } vec_t;

    exp_t        q[$];
    exp_t        e_c;
    vec_t        tbl[11];
    vec_t        none;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] cur;

    initial forever begin
        @(negedge clk);
        if (q.size() > 0) begin
            e_c = q.pop_front();
            n_cmp++;
            if ({nib1, an1, idx1, fd1, nib2, an2, idx2, fd2} !==
                {e_c.nib, e_c.an, e_c.idx, e_c.fd, e_c.nib, e_c.an2, e_c.idx, e_c.fd})
            begin
                n_bad++;
                $display("FAIL scan step %0d: got nib=%h an=%b idx=%0d fd=%b | lz nib=%h an=%b idx=%0d fd=%b ; want nib=%h an=%b idx=%0d fd=%b | lz an=%b",
                         e_c.st, nib1, an1, idx1, fd1, nib2, an2, idx2, fd2,
                         e_c.nib, e_c.an, e_c.idx, e_c.fd, e_c.an2);
            end
        end
    end

    // called at negedge+1; outputs after the following posedge reflect step st of the frame
    task automatic cyc(input int st, input logic ld, input logic [15:0] v, input logic [15:0] shown);
        exp_t        e;
        int          cnt;
        int          idx;
        logic [15:0] hi;
        load_i  = ld;
        value_i = v;
        cnt     = st % 4;
        idx     = st / 4;
        hi      = shown >> (4 * idx);
        e.nib   = hi[3:0];
        e.an    = (cnt == 0) ? 4'hf : ~(4'b0001 << idx);
        e.an2   = (idx > 0 && hi == 16'h0) ? 4'hf : e.an;
        e.idx   = 2'(idx);
        e.fd    = (st == 15);
        e.st    = st;
        q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [15:0] shown, input vec_t r);
        for (int st = 0; st < 16; st++)
            cyc(st, (st == r.a1) || (st == r.a2), (st == r.a2) ? r.v2 : r.v1, shown);
        load_i = 1'b0;
    endtask

    task automatic chk_rst(input string nm);
        n_cmp++;
        if ({nib1, an1, idx1, fd1, nib2, an2, idx2, fd2} !==
            {4'h0, 4'hf, 2'd0, 1'b0, 4'h0, 4'hf, 2'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL %s: got nib=%h an=%b idx=%0d fd=%b lz_an=%b ; want nib=0 an=1111 idx=0 fd=0",
                     nm, nib1, an1, idx1, fd1, an2);
        end
    endtask

    initial begin
        none    = '{16'h0, -1, 16'h0, -1, 16'h0};
        tbl[0]  = '{16'h1234, 3,  16'h0,    -1, 16'h1234};
        tbl[1]  = '{16'h0,    -1, 16'h0,    -1, 16'h1234};
        tbl[2]  = '{16'hABCD, 6,  16'h0,    -1, 16'hABCD};
        tbl[3]  = '{16'h5555, 15, 16'h0,    -1, 16'h5555};
        tbl[4]  = '{16'h1111, 2,  16'h2222, 9,  16'h2222};
        tbl[5]  = '{16'h0040, 0,  16'h0,    -1, 16'h0040};
        tbl[6]  = '{16'h0,    -1, 16'h0,    -1, 16'h0040};
        tbl[7]  = '{16'h0000, 15, 16'h0,    -1, 16'h0000};
        tbl[8]  = '{16'h0,    -1, 16'h0,    -1, 16'h0000};
        tbl[9]  = '{16'h9876, 15, 16'h0,    -1, 16'h9876};
        tbl[10] = '{16'h0,    -1, 16'h0,    -1, 16'h9876};

        #2 rst_n = 1'b0;
        #1 chk_rst("async_reset_no_clk");
        @(negedge clk);
        chk_rst("reset_held_1");
        @(negedge clk);
        chk_rst("reset_held_2");
        #1 rst_n = 1'b1;

        cur = 16'h0;
        for (int i = 0; i < 11; i++) begin
            run_frame(cur, tbl[i]);
            cur = tbl[i].expv;
        end

        for (int st = 0; st < 10; st++)
            cyc(st, st == 2, 16'h7777, cur);
        load_i = 1'b0;
        rst_n  = 1'b0;
        #1 chk_rst("midscan_reset_immediate");
        @(negedge clk);
        chk_rst("midscan_reset_held_1");
        @(negedge clk);
        chk_rst("midscan_reset_held_2");
        #1 rst_n = 1'b1;
        run_frame(16'h0, none);
        run_frame(16'h0, none);

        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
